// File: rtl/vehicle_counter.sv
// Two-road vehicle counter: debounced loop sensors feed BCD accumulators that are
// snapshotted onto the count buses (floored to MIN_COUNT) on every phase_flag toggle.
module vehicle_counter_road #(
    parameter int DEBOUNCE = 16
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       i_sensor,
    input  logic       i_clr,
    output logic [7:0] o_acc,
    output logic       o_sat
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          r_meta, r_sync, r_stable, r_stable_d;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_hi, r_lo;
    logic          r_sat;
    logic          w_event, w_full;

    // Stable level only follows the synchroniser after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_meta     <= 1'b0;
            r_sync     <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_meta     <= i_sensor;
            r_sync     <= r_meta;
            r_stable_d <= r_stable;
            if (r_sync != r_stable) begin
                if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    r_stable <= r_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign w_event = r_stable & ~r_stable_d;
    assign w_full  = (r_hi == 4'd9) && (r_lo == 4'd9);

    // A clear coinciding with an event restarts the count at 1 so the vehicle is kept.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= 4'd0;
            r_lo  <= 4'd0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_hi  <= 4'd0;
            r_lo  <= w_event ? 4'd1 : 4'd0;
            r_sat <= 1'b0;
        end else if (w_event) begin
            if (!w_full) begin
                if (r_lo == 4'd9) begin
                    r_lo <= 4'd0;
                    r_hi <= r_hi + 4'd1;
                end else begin
                    r_lo <= r_lo + 4'd1;
                end
            end
            if ({r_hi, r_lo} >= 8'h98)
                r_sat <= 1'b1;
        end
    end

    assign o_acc = {r_hi, r_lo};
    assign o_sat = r_sat;
endmodule

module vehicle_counter #(
    parameter int DEBOUNCE  = 16,
    parameter int MIN_COUNT = 1
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       sensor1,
    input  logic       sensor2,
    input  logic       phase_flag,
    output logic [3:0] count1Hi,
    output logic [3:0] count1Lo,
    output logic [3:0] count2Hi,
    output logic [3:0] count2Lo,
    output logic       snap,
    output logic       sat1,
    output logic       sat2
);
    localparam logic [7:0] MIN_BCD = {4'(MIN_COUNT / 10), 4'(MIN_COUNT % 10)};

    logic            r_flag, r_snap;
    logic [1:0][7:0] r_cnt;
    logic [1:0][7:0] w_acc;
    logic [1:0]      w_sensor, w_sat;
    logic            w_phase_change;

    assign w_sensor       = {sensor2, sensor1};
    assign w_phase_change = phase_flag ^ r_flag;

    for (genvar g = 0; g < 2; g++) begin : g_road
        vehicle_counter_road #(.DEBOUNCE(DEBOUNCE)) u_road (
            .clock    (clock),
            .rst_n    (rst_n),
            .i_sensor (w_sensor[g]),
            .i_clr    (w_phase_change),
            .o_acc    (w_acc[g]),
            .o_sat    (w_sat[g])
        );
    end

    // BCD ordering matches numeric ordering, so the floor is a plain compare.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_snap <= 1'b0;
            r_cnt  <= {MIN_BCD, MIN_BCD};
        end else begin
            r_flag <= phase_flag;
            r_snap <= w_phase_change;
            if (w_phase_change) begin
                for (int i = 0; i < 2; i++)
                    r_cnt[i] <= (w_acc[i] < MIN_BCD) ? MIN_BCD : w_acc[i];
            end
        end
    end

    assign count1Hi = r_cnt[0][7:4];
    assign count1Lo = r_cnt[0][3:0];
    assign count2Hi = r_cnt[1][7:4];
    assign count2Lo = r_cnt[1][3:0];
    assign snap     = r_snap;
    assign sat1     = w_sat[0];
    assign sat2     = w_sat[1];
endmodule

// File: tb/tb_vehicle_counter.sv
// Randomised scoreboard bench for vehicle_counter: vehicle counts modelled per phase,
// expected snapshots queued at each flag toggle and checked by a snap-driven monitor.
module tb_vehicle_counter;
    localparam int D   = 16;
    localparam int MIN = 1;

    logic       clock = 1'b0;
    logic       rst_n, sensor1, sensor2, phase_flag;
    logic [3:0] count1Hi, count1Lo, count2Hi, count2Lo;
    logic       snap, sat1, sat2;

    vehicle_counter #(.DEBOUNCE(D), .MIN_COUNT(MIN)) dut (
        .clock(clock), .rst_n(rst_n), .sensor1(sensor1), .sensor2(sensor2),
        .phase_flag(phase_flag), .count1Hi(count1Hi), .count1Lo(count1Lo),
        .count2Hi(count2Hi), .count2Lo(count2Lo), .snap(snap), .sat1(sat1), .sat2(sat2)
    );

    always #5 clock = ~clock;

    typedef struct { int c1; int c2; } exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0, snaps = 0;
    int   n1 = 0, n2 = 0;   // vehicles seen this phase

    function automatic logic [7:0] bcd(input int v);
        int f;
        f = (v > 99) ? 99 : v;
        if (f < MIN) f = MIN;
        return {4'(f / 10), 4'(f % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    exp_t me;
    always @(negedge clock) begin
        if (rst_n === 1'b1 && snap === 1'b1) begin
            snaps++;
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_snap actual=1 expected=0 t=%0t", $time);
            end else begin
                me = q.pop_front();
                chk("count1", {count1Hi, count1Lo}, bcd(me.c1));
                chk("count2", {count2Hi, count2Lo}, bcd(me.c2));
                chk("sat1_clear", sat1, 0);
                chk("sat2_clear", sat2, 0);
            end
        end
    end

    // Starts and ends just after a rising edge; only touches the selected sensors.
    task automatic pulse(input bit r1, input bit r2, input int hi, input int lo);
        if (r1) sensor1 = 1'b1;
        if (r2) sensor2 = 1'b1;
        repeat (hi) @(posedge clock);
        #1;
        if (r1) sensor1 = 1'b0;
        if (r2) sensor2 = 1'b0;
        repeat (lo) @(posedge clock);
        #1;
    endtask

    task automatic wait_snaps(input int target);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); #1;
            if (snaps >= target) break;
        end
        if (snaps < target) begin
            checks++; errors++;
            $display("FAIL snap_timeout actual=%0d expected=%0d", snaps, target);
        end
    endtask

    task automatic do_toggle();
        int b;
        b = snaps;
        q.push_back('{n1, n2});
        n1 = 0; n2 = 0;
        phase_flag = ~phase_flag;
        wait_snaps(b + 1);
        @(negedge clock); #1;
        chk("snap_width", snap, 0);
        @(posedge clock); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_c1"}, {count1Hi, count1Lo}, bcd(0));
        chk({tag, "_c2"}, {count2Hi, count2Lo}, bcd(0));
        chk({tag, "_snap"}, snap, 0);
        chk({tag, "_sat1"}, sat1, 0);
        chk({tag, "_sat2"}, sat2, 0);
    endtask

    initial begin
        rst_n = 1'b0; sensor1 = 1'b0; sensor2 = 1'b0; phase_flag = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clock); #1;

        // Seven clean road-1 vehicles, road 2 floors to MIN.
        for (int i = 0; i < 7; i++) begin pulse(1, 0, 3*D, 3*D); n1++; end
        do_toggle();
        do_toggle();   // accumulators must be empty after the previous snapshot

        // Short glitches never count.
        for (int i = 0; i < 50; i++) pulse(0, 1, D-1, D+4);
        do_toggle();

        // Saturation at 99.
        for (int i = 0; i < 120; i++) begin
            pulse(1, 0, D+4, D+4);
            n1++;
            chk("sat1_track", sat1, (n1 >= 99) ? 1 : 0);
        end
        do_toggle();

        // Nine vehicles, then one whose event lands on the snapshot edge.
        for (int i = 0; i < 9; i++) begin pulse(1, 0, D+4, D+4); n1++; end
        sensor1 = 1'b1;
        repeat (D+2) @(posedge clock);
        #1;
        do_toggle();
        n1 = 1;
        repeat (D) @(posedge clock);
        #1;
        sensor1 = 1'b0;
        repeat (D+4) @(posedge clock);
        #1;
        pulse(1, 0, D+4, D+4); n1++;
        do_toggle();

        // Identical timing on both roads, crossing the 09->10 carry.
        for (int i = 0; i < 12; i++) begin pulse(1, 1, D+4, D+4); n1++; n2++; end
        do_toggle();

        // Back-to-back toggles: second snapshot sees only the floor.
        for (int i = 0; i < 3; i++) begin pulse(0, 1, D+4, D+4); n2++; end
        begin
            int b;
            b = snaps;
            q.push_back('{n1, n2}); n1 = 0; n2 = 0;
            phase_flag = ~phase_flag;
            @(posedge clock); #1;
            q.push_back('{0, 0});
            phase_flag = ~phase_flag;
            wait_snaps(b + 2);
            @(posedge clock); #1;
        end

        // Independent random traffic on both roads.
        for (int r = 0; r < 4; r++) begin
            int k1, k2;
            k1 = $urandom_range(0, 30);
            k2 = $urandom_range(0, 30);
            fork
                for (int i = 0; i < k1; i++) pulse(1, 0, $urandom_range(D+2, 2*D), $urandom_range(D+2, 2*D));
                for (int j = 0; j < k2; j++) pulse(0, 1, $urandom_range(D+2, 2*D), $urandom_range(D+2, 2*D));
            join
            n1 += k1; n2 += k2;
            repeat (4) @(posedge clock);
            #1;
            do_toggle();
        end

        // Reset in mid-phase discards partial counts immediately.
        for (int i = 0; i < 5; i++) begin pulse(1, 1, D+4, D+4); n1++; n2++; end
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        n1 = 0; n2 = 0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        phase_flag = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_toggle();

        repeat (4) @(posedge clock);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
